hazard_ctrl: RTL and testbench
==============================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 The module SHALL have these ports, clock and reset first:
- clk  in  1  single pipeline clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high.
- rs_D  in  5  rs field of the instruction in D.
- rt_D  in  5  rt field of the instruction in D.
- Tuse_rs_D  in  2  cycles until D needs rs; 3 = not used.
- Tuse_rt_D  in  2  cycles until D needs rt; 3 = not used.
- A3_D  in  5  destination register of the instruction in D; 0 = no write.
- Tnew_D  in  2  cycles after E entry until the result exists: 0 = PC8 link, 1 = ALU, 2 = load.
- md_start_D  in  1  the instruction in D is a mult or div.
- md_div_D  in  1  qualifies md_start_D; 1 = div.
- md_use_D  in  1  the instruction in D is mfhi, mflo, mthi, mtlo, mult or div.
- Stall  out  1  freeze PC and the F/D register; flush the D/E register.
- ForwardRSD  out  3  D-stage rs mux select: 0 = RF, 1 = PC8_E, 2 = ALUout_M, 3 = WD_W.
- ForwardRTD  out  3  D-stage rt mux select; same encoding as ForwardRSD.
- ForwardRSE  out  2  E-stage rs mux select: 0 = D/E register, 1 = ALUout_M, 2 = WD_W.
- ForwardRTE  out  2  E-stage rt mux select; same encoding as ForwardRSE.
- MD_busy  out  1  the multiply/divide unit is running.

REQ-002 The module SHALL take the already-decided clock and reset as clk and reset: one clock, reset asynchronous and active-high.

Function
REQ-003 The module SHALL keep shadow pipeline registers (A3, Tnew, rs, rt) for the E, M and W stages, and SHALL advance them on every rising edge.
REQ-004 Tnew SHALL decrement by 1 per stage advance and saturate at 0.
REQ-005 When Stall = 1, the E shadow SHALL load a bubble (A3 = 0, Tnew = 0, rs = 0, rt = 0); M and W SHALL advance normally.
REQ-006 A source is "hit" by a stage when the source is nonzero and equals that stage's A3.
- Priority SHALL be E, then M, then W; only the nearest hit counts.
REQ-007 The module SHALL raise Stall for rs when the nearest hit stage has Tnew > Tuse_rs_D, evaluated with that stage's current Tnew. The same rule SHALL apply to rt.
REQ-008 ForwardRSD/RTD SHALL be selected combinationally:
- nearest hit in E with Tnew 0 -> 1;
- nearest hit in M with Tnew 0 -> 2;
- nearest hit in W -> 3;
- otherwise 0.
- A nearest hit that is not ready SHALL give 0, with Stall asserted.
REQ-009 ForwardRSE/RTE SHALL use the E shadow rs/rt against M (Tnew 0) -> 1, else W -> 2, else 0.
REQ-010 Register 0 SHALL never stall and never forward.
REQ-011 The MD counter (4 bits) SHALL behave as follows:
- On an edge with md_start_D = 1 and Stall = 0, it SHALL load 5 for mult or 10 for div.
- Otherwise it SHALL decrement while nonzero.
- MD_busy SHALL equal (counter != 0).
REQ-012 The module SHALL raise Stall when md_use_D = 1 and MD_busy = 1. This includes the first cycle after a load.
REQ-013 Stall SHALL be the OR of the rs, rt and MD conditions.
REQ-014 Stall SHALL be purely combinational from the current state and the D inputs, with zero-cycle latency.
REQ-015 A start arriving while MD_busy = 1 cannot occur, because REQ-012 holds it in D. No reload SHALL occur in that case.

Reset
REQ-016 While reset = 1, all shadow registers SHALL be 0 and the MD counter SHALL be 0. Consequently Stall = 0, all Forward selects = 0 and MD_busy = 0, independent of clk.
REQ-017 Reset asserted mid-stall or mid-MD-operation SHALL abort immediately. The first edge after release SHALL behave as from an empty pipeline.

Structure
REQ-018 A shared package SHALL hold:
- the Forward select encodings (FW_RF, FW_PC8E, FW_ALUM, FW_WDW, FWE_REG, FWE_ALUM, FWE_WDW);
- the Tnew/Tuse codes;
- MULT_CYCLES = 5 and DIV_CYCLES = 10.
REQ-019 One sub-module, md_busy_cnt, SHALL contain the MD counter and busy flag. Everything else SHALL be flat.

Verification
REQ-020 Load-use: the instruction in E has A3 = 8, Tnew = 2 (load); D reads rs = 8 with Tuse = 0 -> Stall = 1 for 2 cycles, then ForwardRSD = 3 (WD_W) on the third cycle.
REQ-021 ALU-to-branch: the instruction in E has A3 = 9, Tnew = 1; D has rt = 9, Tuse_rt = 0 -> Stall = 1 for one cycle, then ForwardRTD = 2.
REQ-022 Priority: registers E, M and W all have A3 = 4 with Tnew 0 -> ForwardRSD = 1 (E wins).
REQ-023 Register 0: all stages have A3 = 0 and Tnew = 2 (load); D has rs = 0, Tuse = 0 -> Stall = 0 and ForwardRSD = 0.
REQ-024 Divide: div issued, then mflo in D -> MD_busy = 1 for 10 cycles and Stall = 1 on each of them; Stall falls on the cycle MD_busy falls.
REQ-025 Async reset: assert reset mid-div with the counter at 6 -> MD_busy = 0 and Stall = 0 before the next clk edge.

Source files
------------

// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the hazard controller: forward select encodings,
// Tnew/Tuse codes, multiply/divide latencies and the shadow-stage record.
package hazard_ctrl_pkg;

    // D-stage forward select encodings
    localparam logic [2:0] FW_RF    = 3'd0;
    localparam logic [2:0] FW_PC8E  = 3'd1;
    localparam logic [2:0] FW_ALUM  = 3'd2;
    localparam logic [2:0] FW_WDW   = 3'd3;

    // E-stage forward select encodings
    localparam logic [1:0] FWE_REG  = 2'd0;
    localparam logic [1:0] FWE_ALUM = 2'd1;
    localparam logic [1:0] FWE_WDW  = 2'd2;

    // Tnew codes (cycles after E entry until the result exists)
    localparam logic [1:0] TNEW_PC8  = 2'd0;
    localparam logic [1:0] TNEW_ALU  = 2'd1;
    localparam logic [1:0] TNEW_LOAD = 2'd2;
    // A result whose Tnew has counted down to this value can be forwarded
    localparam logic [1:0] TNEW_READY = 2'd0;
    // Tuse code for an operand the instruction does not read
    localparam logic [1:0] TUSE_NONE = 2'd3;

    // Multiply/divide unit occupancy in cycles
    localparam logic [3:0] MULT_CYCLES = 4'd5;
    localparam logic [3:0] DIV_CYCLES  = 4'd10;

    // Shadow copy of what a pipeline stage holds, as far as hazards care
    typedef struct packed {
        logic [4:0] a3;
        logic [1:0] tnew;
        logic [4:0] rs;
        logic [4:0] rt;
    } shadow_t;

    localparam shadow_t BUBBLE = '0;

    // Tnew counts down by one per stage and stops at zero
    function automatic logic [1:0] tnew_dec(input logic [1:0] t);
        return (t == 2'd0) ? 2'd0 : t - 2'd1;
    endfunction

    // Register 0 is hard-wired, so it can never be a dependency
    function automatic logic is_hit(input logic [4:0] src, input logic [4:0] a3);
        return (src != 5'd0) && (src == a3);
    endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Decode-side bundle between the D stage and the hazard controller.
interface hazard_ctrl_if;
    logic [4:0] rs_D;
    logic [4:0] rt_D;
    logic [1:0] Tuse_rs_D;
    logic [1:0] Tuse_rt_D;
    logic [4:0] A3_D;
    logic [1:0] Tnew_D;
    logic       md_start_D;
    logic       md_div_D;
    logic       md_use_D;
    logic       Stall;
    logic [2:0] ForwardRSD;
    logic [2:0] ForwardRTD;
    logic [1:0] ForwardRSE;
    logic [1:0] ForwardRTE;
    logic       MD_busy;

    // Decode side: presents the D instruction, consumes stall/forward controls
    modport master (
        output rs_D, rt_D, Tuse_rs_D, Tuse_rt_D, A3_D, Tnew_D,
               md_start_D, md_div_D, md_use_D,
        input  Stall, ForwardRSD, ForwardRTD, ForwardRSE, ForwardRTE, MD_busy
    );

    // Hazard controller side
    modport slave (
        input  rs_D, rt_D, Tuse_rs_D, Tuse_rt_D, A3_D, Tnew_D,
               md_start_D, md_div_D, md_use_D,
        output Stall, ForwardRSD, ForwardRTD, ForwardRSE, ForwardRTE, MD_busy
    );
endinterface

// File: rtl/hazard_ctrl_md_busy_cnt.sv
// Multiply/divide occupancy counter: loaded when a mult/div leaves D,
// counts down to zero, busy while nonzero.
module md_busy_cnt
    import hazard_ctrl_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic div,
    input  logic stall,
    output logic busy
);
    logic [3:0] cnt_reg;
    logic [3:0] cnt_next;

    // Load on an issued start (a stalled start is still sitting in D), else count down
    always_comb begin
        cnt_next = cnt_reg;
        if (start && !stall)
            cnt_next = div ? DIV_CYCLES : MULT_CYCLES;
        else if (cnt_reg != 4'd0)
            cnt_next = cnt_reg - 4'd1;
    end

    // Counter register, cleared immediately by reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            cnt_reg <= 4'd0;
        else
            cnt_reg <= cnt_next;
    end

    assign busy = (cnt_reg != 4'd0);
endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: tracks E/M/W destinations and result timing,
// decides stalls and forward selects for the D and E stages.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    hazard_ctrl_if.slave hz
);
    shadow_t e_reg, m_reg, w_reg;
    shadow_t e_next, m_next, w_next;

    logic       md_busy;
    logic       md_stall;
    logic       stall;
    logic [1:0] src_stall;
    logic [4:0] src_d [2];
    logic [1:0] tuse_d [2];
    logic [4:0] src_e [2];
    logic [2:0] fwd_d_arr [2];
    logic [1:0] fwd_e_arr [2];
    logic       unused_shadow;

    assign src_d[0]  = hz.rs_D;
    assign src_d[1]  = hz.rt_D;
    assign tuse_d[0] = hz.Tuse_rs_D;
    assign tuse_d[1] = hz.Tuse_rt_D;
    assign src_e[0]  = e_reg.rs;
    assign src_e[1]  = e_reg.rt;

    // Per-source (rs, rt) hazard resolution; only the nearest producer counts
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_src
            logic       hit_e, hit_m, hit_w;
            logic       stall_src;
            logic [2:0] fwd_d;
            logic [1:0] fwd_e;

            assign hit_e = is_hit(src_d[gi], e_reg.a3);
            assign hit_m = is_hit(src_d[gi], m_reg.a3);
            assign hit_w = is_hit(src_d[gi], w_reg.a3);

            // D stage: stall if the nearest producer is too late, forward if it is ready
            always_comb begin
                stall_src = 1'b0;
                fwd_d     = FW_RF;
                if (hit_e) begin
                    stall_src = (e_reg.tnew > tuse_d[gi]);
                    if (e_reg.tnew == TNEW_READY) fwd_d = FW_PC8E;
                end else if (hit_m) begin
                    stall_src = (m_reg.tnew > tuse_d[gi]);
                    if (m_reg.tnew == TNEW_READY) fwd_d = FW_ALUM;
                end else if (hit_w) begin
                    stall_src = (w_reg.tnew > tuse_d[gi]);
                    if (w_reg.tnew == TNEW_READY) fwd_d = FW_WDW;
                end
            end

            // E stage: M result when ready, otherwise W write-back data
            always_comb begin
                fwd_e = FWE_REG;
                if (is_hit(src_e[gi], m_reg.a3) && (m_reg.tnew == TNEW_READY))
                    fwd_e = FWE_ALUM;
                else if (is_hit(src_e[gi], w_reg.a3))
                    fwd_e = FWE_WDW;
            end

            assign src_stall[gi] = stall_src;
            assign fwd_d_arr[gi] = fwd_d;
            assign fwd_e_arr[gi] = fwd_e;
        end
    endgenerate

    // MFHI/MFLO/MTHI/MTLO/MULT/DIV must wait for the multiply/divide unit
    assign md_stall = hz.md_use_D & md_busy;
    assign stall    = (|src_stall) | md_stall;

    md_busy_cnt u_md_busy_cnt (
        .clk   (clk),
        .reset (reset),
        .start (hz.md_start_D),
        .div   (hz.md_div_D),
        .stall (stall),
        .busy  (md_busy)
    );

    // Next shadow contents: a stalled D injects a bubble, older stages age by one
    always_comb begin
        e_next = stall ? BUBBLE : '{a3: hz.A3_D, tnew: hz.Tnew_D, rs: hz.rs_D, rt: hz.rt_D};
        m_next = e_reg;
        m_next.tnew = tnew_dec(e_reg.tnew);
        w_next = m_reg;
        w_next.tnew = tnew_dec(m_reg.tnew);
    end

    // Shadow pipeline registers, cleared immediately by reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            e_reg <= BUBBLE;
            m_reg <= BUBBLE;
            w_reg <= BUBBLE;
        end else begin
            e_reg <= e_next;
            m_reg <= m_next;
            w_reg <= w_next;
        end
    end

    // M and W source fields are tracked for completeness but not consulted
    assign unused_shadow = ^{m_reg.rs, m_reg.rt, w_reg.rs, w_reg.rt};

    assign hz.Stall      = stall;
    assign hz.ForwardRSD = fwd_d_arr[0];
    assign hz.ForwardRTD = fwd_d_arr[1];
    assign hz.ForwardRSE = fwd_e_arr[0];
    assign hz.ForwardRTE = fwd_e_arr[1];
    assign hz.MD_busy    = md_busy;
endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: a producer/consumer vector table plus
// hand-written load-use, branch, priority, mult/div and reset sequences.
module tb_hazard_ctrl;
    logic clk;
    logic reset;
    int   tests;
    int   failed;

    hazard_ctrl_if hz_if ();

    hazard_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .hz    (hz_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Producer (a3, tnew) issued, k NOPs, then the consumer is checked in D and in E
    typedef struct {
        int pa3, ptn, k;
        int rs, rt, urs, urt;
        int st, rsd, rtd, rse, rte;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_d(input int rs, input int rt, input int urs, input int urt,
                         input int a3, input int tn);
        hz_if.rs_D      = 5'(rs);
        hz_if.rt_D      = 5'(rt);
        hz_if.Tuse_rs_D = 2'(urs);
        hz_if.Tuse_rt_D = 2'(urt);
        hz_if.A3_D      = 5'(a3);
        hz_if.Tnew_D    = 2'(tn);
        hz_if.md_start_D = 1'b0;
        hz_if.md_div_D   = 1'b0;
        hz_if.md_use_D   = 1'b0;
    endtask

    task automatic set_md(input logic start, input logic div, input logic use_md);
        hz_if.md_start_D = start;
        hz_if.md_div_D   = div;
        hz_if.md_use_D   = use_md;
    endtask

    task automatic nop();
        set_d(0, 0, 3, 3, 0, 0);
    endtask

    task automatic do_reset();
        nop();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tests  = 0;
        failed = 0;
        //            pa3 ptn k  rs rt urs urt  st rsd rtd rse rte
        vecs[0] = '{  5,  1, 0,  5, 0, 1,  3,   0, 0,  0,  1,  0 };  // ALU in E, late use
        vecs[1] = '{  5,  1, 1,  0, 5, 3,  0,   0, 0,  2,  0,  2 };  // ALU in M -> ALUout_M
        vecs[2] = '{  8,  2, 0,  8, 0, 1,  3,   1, 0,  0,  0,  0 };  // load in E, stall
        vecs[3] = '{  8,  2, 1,  8, 0, 1,  3,   0, 0,  0,  2,  0 };  // load in M, not ready, no stall
        vecs[4] = '{  8,  2, 2,  8, 8, 0,  0,   0, 3,  3,  0,  0 };  // load in W -> WD_W both
        vecs[5] = '{ 31,  0, 0, 31, 0, 0,  3,   0, 1,  0,  1,  0 };  // link in E -> PC8_E
        vecs[6] = '{  0,  2, 0,  0, 0, 0,  0,   0, 0,  0,  0,  0 };  // register 0
        vecs[7] = '{  7,  2, 0,  6, 5, 0,  0,   0, 0,  0,  0,  0 };  // unrelated registers
        vecs[8] = '{  9,  2, 0,  0, 9, 3,  3,   0, 0,  0,  0,  0 };  // operand unused
        vecs[9] = '{  9,  1, 0,  0, 9, 3,  0,   1, 0,  0,  0,  0 };  // ALU to branch, stall

        // Reset state, with a hazard-looking D instruction and an MD start held
        reset = 1'b1;
        set_d(8, 9, 0, 0, 8, 2);
        set_md(1'b1, 1'b1, 1'b1);
        #2;
        chk("reset_stall", int'(hz_if.Stall), 0);
        chk("reset_fwd_rsd", int'(hz_if.ForwardRSD), 0);
        chk("reset_busy", int'(hz_if.MD_busy), 0);
        step();
        step();
        chk("reset_hold_busy", int'(hz_if.MD_busy), 0);
        chk("reset_hold_stall", int'(hz_if.Stall), 0);
        chk("reset_hold_fwd_rse", int'(hz_if.ForwardRSE), 0);
        chk("reset_hold_fwd_rte", int'(hz_if.ForwardRTE), 0);
        reset = 1'b0;
        $display("[TB] reset state checked");

        // Table-driven producer/consumer vectors
        for (int v = 0; v < 10; v++) begin
            do_reset();
            set_d(0, 0, 3, 3, vecs[v].pa3, vecs[v].ptn);
            step();
            for (int j = 0; j < vecs[v].k; j++) begin
                nop();
                step();
            end
            set_d(vecs[v].rs, vecs[v].rt, vecs[v].urs, vecs[v].urt, 0, 0);
            #1;
            chk($sformatf("vec%0d_stall", v), int'(hz_if.Stall), vecs[v].st);
            chk($sformatf("vec%0d_rsd", v), int'(hz_if.ForwardRSD), vecs[v].rsd);
            chk($sformatf("vec%0d_rtd", v), int'(hz_if.ForwardRTD), vecs[v].rtd);
            step();
            nop();
            #1;
            chk($sformatf("vec%0d_rse", v), int'(hz_if.ForwardRSE), vecs[v].rse);
            chk($sformatf("vec%0d_rte", v), int'(hz_if.ForwardRTE), vecs[v].rte);
            $display("[TB] vector %0d applied: producer r%0d tnew %0d", v, vecs[v].pa3, vecs[v].ptn);
        end

        // Load-use: two stall cycles, then WD_W forward
        do_reset();
        set_d(0, 0, 3, 3, 8, 2);
        step();
        set_d(8, 0, 0, 3, 0, 0);
        #1;
        chk("lu_stall_c1", int'(hz_if.Stall), 1);
        step();
        chk("lu_stall_c2", int'(hz_if.Stall), 1);
        chk("lu_rsd_c2", int'(hz_if.ForwardRSD), 0);
        step();
        chk("lu_stall_c3", int'(hz_if.Stall), 0);
        chk("lu_rsd_c3", int'(hz_if.ForwardRSD), 3);
        $display("[TB] load-use sequence done");

        // ALU to branch: one stall cycle, then ALUout_M forward
        do_reset();
        set_d(0, 0, 3, 3, 9, 1);
        step();
        set_d(0, 9, 3, 0, 0, 0);
        #1;
        chk("br_stall_c1", int'(hz_if.Stall), 1);
        step();
        chk("br_stall_c2", int'(hz_if.Stall), 0);
        chk("br_rtd_c2", int'(hz_if.ForwardRTD), 2);
        $display("[TB] alu-to-branch sequence done");

        // Priority: E, M and W all write r4 with Tnew 0
        do_reset();
        for (int j = 0; j < 3; j++) begin
            set_d(0, 0, 3, 3, 4, 0);
            step();
        end
        set_d(4, 0, 0, 3, 0, 0);
        #1;
        chk("prio_rsd", int'(hz_if.ForwardRSD), 1);
        chk("prio_stall", int'(hz_if.Stall), 0);
        step();
        nop();
        #1;
        chk("prio_rse", int'(hz_if.ForwardRSE), 1);
        $display("[TB] priority sequence done");

        // Mult, with a second mult held in D: exactly 5 busy cycles, then reload
        do_reset();
        set_md(1'b1, 1'b0, 1'b1);
        #1;
        chk("mult_busy_pre", int'(hz_if.MD_busy), 0);
        chk("mult_stall_pre", int'(hz_if.Stall), 0);
        step();
        for (int j = 0; j < 5; j++) begin
            chk($sformatf("mult_busy_c%0d", j + 1), int'(hz_if.MD_busy), 1);
            chk($sformatf("mult_stall_c%0d", j + 1), int'(hz_if.Stall), 1);
            step();
        end
        chk("mult_busy_end", int'(hz_if.MD_busy), 0);
        chk("mult_stall_end", int'(hz_if.Stall), 0);
        step();
        chk("mult_reload_busy", int'(hz_if.MD_busy), 1);
        $display("[TB] mult sequence done");

        // Divide then mflo: 10 busy/stall cycles, both fall together
        do_reset();
        set_md(1'b1, 1'b1, 1'b1);
        step();
        set_md(1'b0, 1'b0, 1'b1);
        for (int j = 0; j < 10; j++) begin
            #1;
            chk($sformatf("div_busy_c%0d", j + 1), int'(hz_if.MD_busy), 1);
            chk($sformatf("div_stall_c%0d", j + 1), int'(hz_if.Stall), 1);
            step();
        end
        #1;
        chk("div_busy_end", int'(hz_if.MD_busy), 0);
        chk("div_stall_end", int'(hz_if.Stall), 0);
        $display("[TB] divide sequence done");

        // Async reset mid-divide with counter at 6
        do_reset();
        set_md(1'b1, 1'b1, 1'b1);
        step();
        set_md(1'b0, 1'b0, 1'b1);
        for (int j = 0; j < 4; j++) step();
        chk("arst_busy_before", int'(hz_if.MD_busy), 1);
        reset = 1'b1;
        #1;
        chk("arst_busy", int'(hz_if.MD_busy), 0);
        chk("arst_stall", int'(hz_if.Stall), 0);
        reset = 1'b0;
        #1;
        step();
        chk("arst_after_busy", int'(hz_if.MD_busy), 0);
        chk("arst_after_stall", int'(hz_if.Stall), 0);
        $display("[TB] async reset sequence done");

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
